// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_lite_pkg
// Description : Shared types and constants for the AXI4-Lite pattern master.
// Revision    : 1.0 - initial release
// ============================================================================

package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] WSTRB_ALL   = 4'hF;
    localparam logic [2:0] PROT_NONE   = 3'b000;

    function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_pattern_master_if.sv
`default_nettype none
// ============================================================================
// Interface   : axi_lite_pattern_master_if
// Description : AXI4-Lite bus bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================

interface axi_lite_pattern_master_if;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_lite_pattern_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pattern_master
// Description : Writes SEED^addr over a word range, reads it back, counts errors.
// Revision    : 1.0 - initial release
// ============================================================================

module axi_lite_pattern_master
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_WORDS = 16,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
    input  wire logic                  aclk,
    input  wire logic                  areset,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                err_count,
    output logic [31:0]                err_addr,
    axi_lite_pattern_master_if.master  m_axi
);

    localparam logic [31:0] c_base_word = {BASE_ADDR[31:2], 2'b00};
    localparam logic [15:0] c_last_idx  = 16'(NUM_WORDS - 1);

    state_e      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic        aw_sent_q, aw_sent_d;
    logic        w_sent_q, w_sent_d;
    logic [15:0] err_count_q, err_count_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        first_err_q, first_err_d;

    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_data;
    logic        w_last;
    logic        w_fail;

    // 32-bit sum wraps naturally past the top of the address space.
    assign w_cur_addr = c_base_word + {14'd0, idx_q, 2'b00};
    assign w_cur_data = pattern(w_cur_addr, SEED);
    assign w_last     = (idx_q == c_last_idx);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            idx_q       <= 16'd0;
            aw_sent_q   <= 1'b0;
            w_sent_q    <= 1'b0;
            err_count_q <= 16'd0;
            err_addr_q  <= 32'd0;
            first_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            aw_sent_q   <= aw_sent_d;
            w_sent_q    <= w_sent_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            first_err_q <= first_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        aw_sent_d   = aw_sent_q;
        w_sent_d    = w_sent_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        first_err_d = first_err_q;
        w_fail      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WR_REQ;
                    idx_d       = 16'd0;
                    aw_sent_d   = 1'b0;
                    w_sent_d    = 1'b0;
                    err_count_d = 16'd0;
                    err_addr_d  = 32'd0;
                    first_err_d = 1'b0;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; move on once both are done.
                if (m_axi.awvalid && m_axi.awready) aw_sent_d = 1'b1;
                if (m_axi.wvalid && m_axi.wready)   w_sent_d  = 1'b1;
                if (aw_sent_d && w_sent_d)          state_d   = WR_RSP;
            end
            WR_RSP: begin
                if (m_axi.bvalid) begin
                    w_fail    = (m_axi.bresp != RESP_OKAY);
                    aw_sent_d = 1'b0;
                    w_sent_d  = 1'b0;
                    if (w_last) begin
                        state_d = RD_REQ;
                        idx_d   = 16'd0;
                    end else begin
                        state_d = WR_REQ;
                        idx_d   = idx_q + 16'd1;
                    end
                end
            end
            RD_REQ: begin
                if (m_axi.arready) state_d = RD_RSP;
            end
            RD_RSP: begin
                if (m_axi.rvalid) begin
                    w_fail = (m_axi.rresp != RESP_OKAY) || (m_axi.rdata != w_cur_data);
                    if (w_last) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_REQ;
                        idx_d   = idx_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_fail) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (!first_err_q) begin
                first_err_d = 1'b1;
                err_addr_d  = w_cur_addr;
            end
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

    // Address/data are zero outside their request phase so reset shows all zeros.
    assign m_axi.awvalid = (state_q == WR_REQ) && !aw_sent_q;
    assign m_axi.awaddr  = (state_q == WR_REQ) ? w_cur_addr : 32'd0;
    assign m_axi.awprot  = PROT_NONE;
    assign m_axi.wvalid  = (state_q == WR_REQ) && !w_sent_q;
    assign m_axi.wdata   = (state_q == WR_REQ) ? w_cur_data : 32'd0;
    assign m_axi.wstrb   = WSTRB_ALL;
    assign m_axi.bready  = (state_q == WR_RSP);
    assign m_axi.arvalid = (state_q == RD_REQ);
    assign m_axi.araddr  = (state_q == RD_REQ) ? w_cur_addr : 32'd0;
    assign m_axi.arprot  = PROT_NONE;
    assign m_axi.rready  = (state_q == RD_RSP);

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_pattern_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_pattern_master
// Description : Four pattern-master instances, each behind a fault-injecting slave.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_axi_lite_pattern_master;
    import axi_lite_pkg::*;

    localparam int          NI     = 4;
    localparam logic [31:0] SEED_P = 32'hA5A5_0000;
    localparam logic [31:0] BASE_P [NI] = '{32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFFC, 32'hFFFF_FFFF};
    localparam int          NUMW_P [NI] = '{4, 4, 1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic [15:0] errc  [NI];
    logic [31:0] erra  [NI];

    int          cfg_aw [NI];
    int          cfg_w  [NI];
    int          cfg_ar [NI];
    logic [15:0] bmask  [NI];
    logic [15:0] rmask  [NI];
    logic [15:0] dmask  [NI];

    logic awv [NI], wv [NI], arv [NI], bry [NI], rry [NI];
    int   st_wr [NI], st_wbad [NI], st_rd [NI], st_rbad [NI];
    int   st_awh [NI], st_wh [NI], st_brh [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: address and data of word i, straight from the addressing rule.
    function automatic logic [31:0] m_addr(int k, int i);
        logic [31:0] b;
        b = BASE_P[k];
        return {b[31:2], 2'b00} + 32'(4 * i);
    endfunction

    function automatic logic [31:0] m_data(int k, int i);
        return SEED_P ^ m_addr(k, i);
    endfunction

    function automatic int widx(int k, logic [31:0] a);
        logic [31:0] off;
        off = a - m_addr(k, 0);
        return int'(off[5:2]);
    endfunction

    function automatic int pick(int c);
        return (c < 0) ? int'($urandom_range(0, 3)) : c;
    endfunction

    // Writes all precede reads, so the first failure is the lowest faulty write,
    // else the lowest faulty read; a read with both faults counts once.
    function automatic void m_err(int k, logic [15:0] bm, logic [15:0] rm, logic [15:0] dm,
                                  output int cnt, output logic [31:0] fa);
        bit seen;
        seen = 0;
        cnt  = 0;
        fa   = 32'd0;
        for (int i = 0; i < NUMW_P[k]; i++)
            if (bm[i]) begin
                cnt++;
                if (!seen) begin seen = 1; fa = m_addr(k, i); end
            end
        for (int i = 0; i < NUMW_P[k]; i++)
            if (rm[i] || dm[i]) begin
                cnt++;
                if (!seen) begin seen = 1; fa = m_addr(k, i); end
            end
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_dut
        axi_lite_pattern_master_if bus ();

        axi_lite_pattern_master #(
            .BASE_ADDR (BASE_P[k]),
            .NUM_WORDS (NUMW_P[k]),
            .SEED      (SEED_P)
        ) u_dut (
            .aclk      (clk),
            .areset    (rst),
            .start     (start[k]),
            .busy      (busy[k]),
            .done      (done[k]),
            .err_count (errc[k]),
            .err_addr  (erra[k]),
            .m_axi     (bus.master)
        );

        int          aw_cnt, w_cnt, ar_cnt, aw_dly, w_dly, ar_dly;
        logic        aw_got, w_got, bvalid_r, rvalid_r;
        logic [31:0] aw_a, w_d, rdata_r;
        logic [1:0]  bresp_r, rresp_r;
        logic [31:0] mem [16];
        int          wr_n, wbad_n, rd_n, rbad_n, awh_n, wh_n, brh_n;
        logic        aw_hs, w_hs, ar_hs, wr_fire;
        logic [31:0] cur_a, cur_d;

        assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
        assign bus.wready  = bus.wvalid  && (w_cnt  >= w_dly);
        assign bus.arready = bus.arvalid && (ar_cnt >= ar_dly);
        assign bus.bvalid  = bvalid_r;
        assign bus.bresp   = bresp_r;
        assign bus.rvalid  = rvalid_r;
        assign bus.rdata   = rdata_r;
        assign bus.rresp   = rresp_r;

        assign aw_hs   = bus.awvalid && bus.awready;
        assign w_hs    = bus.wvalid  && bus.wready;
        assign ar_hs   = bus.arvalid && bus.arready;
        assign cur_a   = aw_got ? aw_a : bus.awaddr;
        assign cur_d   = w_got  ? w_d  : bus.wdata;
        assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);

        always @(posedge clk) begin
            if (rst) begin
                aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
                aw_dly <= 0; w_dly <= 0; ar_dly <= 0;
                aw_got <= 1'b0; w_got <= 1'b0;
                aw_a <= 32'd0; w_d <= 32'd0;
                bvalid_r <= 1'b0; rvalid_r <= 1'b0;
                bresp_r <= RESP_OKAY; rresp_r <= RESP_OKAY; rdata_r <= 32'd0;
                wr_n <= 0; wbad_n <= 0; rd_n <= 0; rbad_n <= 0;
                awh_n <= 0; wh_n <= 0; brh_n <= 0;
            end else begin
                if (bus.awvalid) awh_n <= awh_n + 1;
                if (bus.wvalid)  wh_n  <= wh_n + 1;
                if (bus.bready)  brh_n <= brh_n + 1;

                if (!bus.awvalid) begin
                    aw_cnt <= 0;
                    aw_dly <= pick(cfg_aw[k]);
                end else if (aw_hs) begin
                    aw_got <= 1'b1; aw_a <= bus.awaddr; aw_cnt <= 0;
                end else aw_cnt <= aw_cnt + 1;

                if (!bus.wvalid) begin
                    w_cnt <= 0;
                    w_dly <= pick(cfg_w[k]);
                end else if (w_hs) begin
                    w_got <= 1'b1; w_d <= bus.wdata; w_cnt <= 0;
                end else w_cnt <= w_cnt + 1;

                if (wr_fire) begin
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                    mem[cur_a[5:2]] <= cur_d;
                    if (cur_a != m_addr(k, wr_n) || cur_d != m_data(k, wr_n)) wbad_n <= wbad_n + 1;
                    wr_n     <= wr_n + 1;
                    bvalid_r <= 1'b1;
                    bresp_r  <= bmask[k][widx(k, cur_a)] ? RESP_SLVERR : RESP_OKAY;
                end else if (bvalid_r && bus.bready) bvalid_r <= 1'b0;

                if (!bus.arvalid) begin
                    ar_cnt <= 0;
                    ar_dly <= pick(cfg_ar[k]);
                end else if (ar_hs) begin
                    ar_cnt   <= 0;
                    rvalid_r <= 1'b1;
                    rdata_r  <= mem[bus.araddr[5:2]] ^ (dmask[k][widx(k, bus.araddr)] ? 32'h1 : 32'h0);
                    rresp_r  <= rmask[k][widx(k, bus.araddr)] ? RESP_SLVERR : RESP_OKAY;
                    if (bus.araddr != m_addr(k, rd_n)) rbad_n <= rbad_n + 1;
                    rd_n <= rd_n + 1;
                end else ar_cnt <= ar_cnt + 1;

                if (rvalid_r && bus.rready) rvalid_r <= 1'b0;
            end
        end

        assign awv[k]     = bus.awvalid;
        assign wv[k]      = bus.wvalid;
        assign arv[k]     = bus.arvalid;
        assign bry[k]     = bus.bready;
        assign rry[k]     = bus.rready;
        assign st_wr[k]   = wr_n;
        assign st_wbad[k] = wbad_n;
        assign st_rd[k]   = rd_n;
        assign st_rbad[k] = rbad_n;
        assign st_awh[k]  = awh_n;
        assign st_wh[k]   = wh_n;
        assign st_brh[k]  = brh_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic configure(int k, int aw, int w, int ar, logic [15:0] bm, logic [15:0] rm, logic [15:0] dm);
        cfg_aw[k] = aw; cfg_w[k] = w; cfg_ar[k] = ar;
        bmask[k] = bm; rmask[k] = rm; dmask[k] = dm;
    endtask

    task automatic start_run(int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(int k, output int cyc, output bit ok);
        cyc = 0;
        ok  = 0;
        for (int t = 0; t < 4000; t++) begin
            if (done[k]) begin ok = 1; break; end
            if (busy[k]) cyc++;
            tick();
        end
    endtask

    typedef struct {
        int          k;
        int          aw;
        int          w;
        int          ar;
        logic [15:0] bm;
        logic [15:0] rm;
        logic [15:0] dm;
        int          exp_cnt;
        logic [31:0] exp_addr;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   cyc, cyc_tot, k, n, ecnt;
        bit   ok;
        logic [31:0] eaddr;
        logic [15:0] lim, bm, rm, dm;

        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            configure(i, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        end

        vecs.push_back('{0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 32'h0000_0000});
        vecs.push_back('{0, 3, 0, 0, 16'h0, 16'h0, 16'h0, 0, 32'h0000_0000});
        vecs.push_back('{1, 0, 0, 0, 16'h0, 16'h0, 16'h4, 1, 32'h0000_0108});
        vecs.push_back('{1, 0, 1, 2, 16'h2, 16'h8, 16'h8, 2, 32'h0000_0104});
        vecs.push_back('{2, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 32'h0000_0000});
        vecs.push_back('{3, 1, 2, 0, 16'h0, 16'h0, 16'h0, 0, 32'h0000_0000});
        vecs.push_back('{1, 2, 0, 1, 16'hF, 16'h5, 16'h6, 7, 32'h0000_0100});
        vecs.push_back('{2, 0, 0, 3, 16'h0, 16'h1, 16'h0, 1, 32'hFFFF_FFFC});
        vecs.push_back('{3, 0, 0, 0, 16'h1, 16'h0, 16'h0, 1, 32'hFFFF_FFFC});

        foreach (vecs[v]) begin
            k = vecs[v].k;
            n = NUMW_P[k];
            configure(k, vecs[v].aw, vecs[v].w, vecs[v].ar, vecs[v].bm, vecs[v].rm, vecs[v].dm);
            do_reset();
            check($sformatf("v%0d rst_busy", v), busy[k], 0);
            check($sformatf("v%0d rst_done", v), done[k], 0);
            check($sformatf("v%0d rst_errc", v), errc[k], 0);
            check($sformatf("v%0d rst_erra", v), erra[k], 0);
            check($sformatf("v%0d rst_awvalid", v), awv[k], 0);
            start_run(k);
            check($sformatf("v%0d busy_n1", v), busy[k], 1);
            check($sformatf("v%0d awvalid_n1", v), awv[k], 1);
            check($sformatf("v%0d wvalid_n1", v), wv[k], 1);
            wait_done(k, cyc, ok);
            check($sformatf("v%0d done", v), done[k], 1);
            check($sformatf("v%0d cycles", v), cyc,
                  n * ((vecs[v].aw > vecs[v].w ? vecs[v].aw : vecs[v].w) + vecs[v].ar + 4));
            check($sformatf("v%0d err_count", v), errc[k], vecs[v].exp_cnt);
            check($sformatf("v%0d err_addr", v), erra[k], vecs[v].exp_addr);
            check($sformatf("v%0d writes", v), st_wr[k], n);
            check($sformatf("v%0d reads", v), st_rd[k], n);
            check($sformatf("v%0d write_mismatch", v), st_wbad[k], 0);
            check($sformatf("v%0d read_addr_mismatch", v), st_rbad[k], 0);
            check($sformatf("v%0d awvalid_cycles", v), st_awh[k], n * (vecs[v].aw + 1));
            check($sformatf("v%0d wvalid_cycles", v), st_wh[k], n * (vecs[v].w + 1));
            check($sformatf("v%0d bready_cycles", v), st_brh[k], n);
        end

        // done/err hold in DONE, cleared by next start; a start while busy is ignored.
        configure(1, 0, 0, 0, 16'h2, 16'h0, 16'h0);
        do_reset();
        start_run(1);
        wait_done(1, cyc, ok);
        repeat (5) tick();
        check("hold_done", done[1], 1);
        check("hold_errc", errc[1], 1);
        check("hold_erra", erra[1], 32'h0000_0104);
        configure(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        start_run(1);
        check("restart_errc_clear", errc[1], 0);
        check("restart_erra_clear", erra[1], 0);
        check("restart_done_low", done[1], 0);
        cyc_tot = 0;
        repeat (3) begin
            if (busy[1]) cyc_tot++;
            tick();
        end
        start[1] = 1'b1;
        if (busy[1]) cyc_tot++;
        tick();
        start[1] = 1'b0;
        wait_done(1, cyc, ok);
        check("busy_start_done", done[1], 1);
        check("busy_start_cycles", cyc_tot + cyc, 16);
        check("busy_start_errc", errc[1], 0);

        // Reset mid-write with AW still pending.
        configure(0, 3, 0, 0, 16'h0, 16'h0, 16'h0);
        do_reset();
        start_run(0);
        tick();
        check("midrst_pre_awvalid", awv[0], 1);
        rst = 1'b1;
        tick();
        check("midrst_awvalid", awv[0], 0);
        check("midrst_wvalid", wv[0], 0);
        check("midrst_arvalid", arv[0], 0);
        check("midrst_bready", bry[0], 0);
        check("midrst_rready", rry[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_done", done[0], 0);
        rst = 1'b0;
        configure(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        start_run(0);
        wait_done(0, cyc, ok);
        check("midrst_rerun_done", done[0], 1);
        check("midrst_rerun_errc", errc[0], 0);
        check("midrst_rerun_erra", erra[0], 0);
        check("midrst_rerun_writes", st_wr[0], 4);
        check("midrst_rerun_wmismatch", st_wbad[0], 0);

        // Random ready timing and fault placement against the error model.
        for (int r = 0; r < 24; r++) begin
            k   = int'($urandom_range(0, NI - 1));
            n   = NUMW_P[k];
            lim = 16'((1 << n) - 1);
            bm  = 16'($urandom) & 16'($urandom) & lim;
            rm  = 16'($urandom) & 16'($urandom) & lim;
            dm  = 16'($urandom) & 16'($urandom) & lim;
            configure(k, -1, -1, -1, bm, rm, dm);
            m_err(k, bm, rm, dm, ecnt, eaddr);
            do_reset();
            start_run(k);
            wait_done(k, cyc, ok);
            check($sformatf("r%0d k%0d done", r, k), done[k], 1);
            check($sformatf("r%0d k%0d err_count", r, k), errc[k], ecnt);
            check($sformatf("r%0d k%0d err_addr", r, k), erra[k], eaddr);
            check($sformatf("r%0d k%0d writes", r, k), st_wr[k], n);
            check($sformatf("r%0d k%0d write_mismatch", r, k), st_wbad[k], 0);
            check($sformatf("r%0d k%0d read_addr_mismatch", r, k), st_rbad[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
